// File: rtl/coproc_issue.sv
// Initiator side of the go/busy/fmt/cnt/a/y coprocessor handshake.
// Requests from the CPU are issued to a multi-cycle unit one at a time. The
// block holds one pending request, supervises the unit with an acknowledge
// timeout and a completion timeout, and returns each result with a one-cycle
// valid strobe.
module coproc_issue #(
    parameter int WIDTH    = 16,
    parameter int ACK_CYC  = 2,
    parameter int DONE_CYC = 64
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             cpu_req,
    input  logic [1:0]       cpu_fmt,
    input  logic [4:0]       cpu_cnt,
    input  logic [WIDTH-1:0] cpu_a,
    output logic             cpu_busy,
    output logic             cpu_valid,
    output logic [WIDTH-1:0] cpu_y,
    output logic             err,
    input  logic             err_clr,
    output logic             u_go,
    output logic [1:0]       u_fmt,
    output logic [4:0]       u_cnt,
    output logic [WIDTH-1:0] u_a,
    input  logic             u_busy,
    input  logic [WIDTH-1:0] u_y
);

    localparam int CNT_MAX = (ACK_CYC > DONE_CYC) ? ACK_CYC : DONE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             slot_full_q, slot_full_d;
    logic [1:0]       slot_fmt_q, slot_fmt_d;
    logic [4:0]       slot_cnt_q, slot_cnt_d;
    logic [WIDTH-1:0] slot_a_q, slot_a_d;
    logic             u_go_q, u_go_d;
    logic [1:0]       u_fmt_q, u_fmt_d;
    logic [4:0]       u_cnt_q, u_cnt_d;
    logic [WIDTH-1:0] u_a_q, u_a_d;
    logic [WIDTH-1:0] cpu_y_q, cpu_y_d;
    logic             cpu_valid_q, cpu_valid_d;
    logic             cpu_busy_q, cpu_busy_d;
    logic             err_q, err_d;

    logic             err_set;
    logic             abort;
    logic             req_taken;

    // Next-state, operand routing, pending-slot and error logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        slot_full_d = slot_full_q;
        slot_fmt_d  = slot_fmt_q;
        slot_cnt_d  = slot_cnt_q;
        slot_a_d    = slot_a_q;
        u_fmt_d     = u_fmt_q;
        u_cnt_d     = u_cnt_q;
        u_a_d       = u_a_q;
        cpu_y_d     = cpu_y_q;
        cpu_valid_d = 1'b0;
        err_set     = 1'b0;
        abort       = 1'b0;
        req_taken   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    u_fmt_d   = cpu_fmt;
                    u_cnt_d   = cpu_cnt;
                    u_a_d     = cpu_a;
                    req_taken = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(ACK_CYC);
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (u_busy) begin
                    cnt_d   = CW'(DONE_CYC);
                    state_d = S_WAIT_DONE;
                end else if (cnt_q <= CW'(1)) begin
                    // Unit never acknowledged: treat as a zero-length op.
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!u_busy) begin
                    state_d = S_DONE;
                end else if (cnt_q <= CW'(1)) begin
                    err_set = 1'b1;
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                cpu_y_d     = u_y;
                cpu_valid_d = 1'b1;
                if (slot_full_q) begin
                    u_fmt_d     = slot_fmt_q;
                    u_cnt_d     = slot_cnt_q;
                    u_a_d       = slot_a_q;
                    slot_full_d = 1'b0;
                    state_d     = S_ISSUE;
                end else if (cpu_req) begin
                    // Empty slot: a request arriving now goes straight to the unit.
                    u_fmt_d   = cpu_fmt;
                    u_cnt_d   = cpu_cnt;
                    u_a_d     = cpu_a;
                    req_taken = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request while an op is in flight goes to the pending slot; the slot
        // counts as free in DONE because it is being unloaded this cycle.
        if (cpu_req && !req_taken && (state_q != S_IDLE)) begin
            if (!slot_full_q || (state_q == S_DONE)) begin
                slot_full_d = 1'b1;
                slot_fmt_d  = cpu_fmt;
                slot_cnt_d  = cpu_cnt;
                slot_a_d    = cpu_a;
            end else begin
                err_set = 1'b1;
            end
        end

        if (abort) begin
            slot_full_d = 1'b0;
        end

        // Set wins over clear when both happen in the same cycle.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        u_go_d     = (state_d == S_ISSUE);
        cpu_busy_d = (state_d != S_IDLE) || slot_full_d;
    end

    // State and registered outputs; everything returns to zero on arst.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            slot_full_q <= 1'b0;
            // NOTE: the slot payload is reset as well; it is a handful of
            // flops, not a RAM, so a reset costs nothing and keeps it defined.
            slot_fmt_q  <= '0;
            slot_cnt_q  <= '0;
            slot_a_q    <= '0;
            u_go_q      <= 1'b0;
            u_fmt_q     <= '0;
            u_cnt_q     <= '0;
            u_a_q       <= '0;
            cpu_y_q     <= '0;
            cpu_valid_q <= 1'b0;
            cpu_busy_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_full_q <= slot_full_d;
            slot_fmt_q  <= slot_fmt_d;
            slot_cnt_q  <= slot_cnt_d;
            slot_a_q    <= slot_a_d;
            u_go_q      <= u_go_d;
            u_fmt_q     <= u_fmt_d;
            u_cnt_q     <= u_cnt_d;
            u_a_q       <= u_a_d;
            cpu_y_q     <= cpu_y_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_busy_q  <= cpu_busy_d;
            err_q       <= err_d;
        end
    end

    assign u_go      = u_go_q;
    assign u_fmt     = u_fmt_q;
    assign u_cnt     = u_cnt_q;
    assign u_a       = u_a_q;
    assign cpu_y     = cpu_y_q;
    assign cpu_valid = cpu_valid_q;
    assign cpu_busy  = cpu_busy_q;
    assign err       = err_q;

endmodule
